icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Miss/refill sequencer for the instruction cache.
- Accepts a line miss from the i_cache, invalidates the target line and issues one burst read to the memory bus.
- Writes each returned beat into the data array and commits the tag when the line completes.
- Handles fetch redirects (flush) by draining the outstanding burst without committing.
- Sits between the i_cache arrays and the memory-side bus port.

Parameters:
ADR_WIDTH, 32, byte address width
LINE_BYTES, 16, cache line size in bytes (power of 2)
BUS_BYTES, 4, bytes per memory beat (power of 2, at most LINE_BYTES)
INDEX_W, 6, set index width; OFFSET_W = log2(LINE_BYTES), BEATS = LINE_BYTES/BUS_BYTES, WORD_W = max(1, log2(BEATS)), TAG_W = ADR_WIDTH-INDEX_W-OFFSET_W

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
miss_valid  in  1  i_cache reports a miss
miss_adr  in  ADR_WIDTH  missing fetch address
miss_ready  out  1  high only in IDLE
flush  in  1  fetch redirect; abandon current refill
mem_req_valid  out  1  burst read request
mem_req_adr  out  ADR_WIDTH  burst start address
mem_req_ready  in  1  bus accepts request
mem_rsp_valid  in  1  beat valid (bus never stalls a beat)
mem_rsp_data  in  BUS_BYTES*8  beat data
mem_rsp_err  in  1  beat bus error
arr_we  out  1  data array write enable
arr_index  out  INDEX_W  set being refilled
arr_word  out  WORD_W  beat slot within line
arr_wdata  out  BUS_BYTES*8  data to array
tag_we  out  1  tag array write enable
tag_value  out  TAG_W  tag to write
tag_valid  out  1  valid bit to write
refill_done  out  1  one-cycle pulse on completion
refill_err  out  1  qualifies refill_done; line left invalid
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs 0 except miss_ready=1. Beat counter 0, err and abort flags cleared. Reset mid-burst returns to IDLE; the bus is reset on the same rst_n.
- IDLE:
  - On miss_valid & !flush: latch index/tag/word from miss_adr.
  - Same cycle, combinationally: tag_we=1, tag_valid=0, tag_value=latched tag (invalidate the line).
  - Next state REQ.
  - miss_valid & flush: ignored, stay IDLE.
- REQ:
  - mem_req_valid=1; mem_req_adr = line base (offset bits zero).
  - Request held stable until mem_req_ready; never retracted.
  - On accept: go BEAT, or DRAIN if the abort flag is set.
  - flush while in REQ sets the abort flag.
- BEAT: per mem_rsp_valid:
  - Combinational, zero latency: arr_we=1, arr_wdata=mem_rsp_data, arr_word = (start_word + cnt) mod BEATS.
  - Counter increments.
  - mem_rsp_err sets the sticky err flag; the beat is still written.
  - After beat BEATS-1, go COMMIT.
  - flush: that cycle's beat (if valid) is still written, then go DRAIN. If it was the last beat, go IDLE directly with no pulse.
- DRAIN:
  - Consume the remaining beats with arr_we=0.
  - After the last beat, go IDLE. No tag write, no refill_done.
- COMMIT, one cycle:
  - If !err: tag_we=1, tag_valid=1. If err: tag_we=0.
  - refill_done=1, refill_err=err; go IDLE.
  - flush in COMMIT is ignored; the line is already complete.
- Arithmetic: word slot wraps modulo BEATS; counter width WORD_W+1 so the terminal count is unambiguous.
- BEATS==1: BEAT exits after one beat.
- miss_ready=0 in every state except IDLE; a miss presented while busy is held by the i_cache.

Optional Feature:
ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - mem_req_adr = miss_adr aligned to BUS_BYTES; start_word = miss word; bus returns beats wrapping.
  - Extra outputs cwf_valid (1) and cwf_data (BUS_BYTES*8) pulse with the first beat of a non-aborted refill, giving early forward to decode.
- Undefined: start_word=0, line-base request, cwf ports absent.

Decomposition:
- com_pkg:
  - icache_refill_state_t enum {IDLE, REQ, BEAT, DRAIN, COMMIT}.
  - Default LINE_BYTES/BUS_BYTES localparams.
  - icache_line_adr_t struct {tag, index, offset}, used for address slicing.
- No sub-module; counter and FSM in one module.

Test Plan:
- Parameters 16/4, miss_adr=0x0000_1238, ready immediate, 4 clean beats:
  - IDLE cycle: tag_we with valid=0.
  - Request adr 0x1230.
  - arr_word 0,1,2,3, index=0x23.
  - COMMIT: tag_we valid=1, tag=0x4, refill_done=1, refill_err=0.
  - Total 7 cycles IDLE→IDLE.
- mem_req_ready low for 5 cycles: mem_req_valid and mem_req_adr stable throughout; no beats written early.
- mem_rsp_err on beat 2: all 4 beats written; COMMIT has tag_we=0, refill_done=1, refill_err=1.
- flush after beat 1:
  - Beat 1 written, beats 2–3 absorbed with arr_we=0.
  - No done pulse; miss_ready returns after beat 3.
  - A new miss is then accepted normally.
- flush during REQ before accept: request held until ready, then DRAIN of 4 beats, no array writes.
- With ICACHE_CRITICAL_WORD_FIRST_EN, miss_adr=0x1238:
  - Request adr 0x1238.
  - arr_word 2,3,0,1.
  - cwf_valid with the first beat's data.

Source files
------------

// File: rtl/com_pkg.sv
// ----------------------------------------------------------------------------
// com_pkg
// Shared types and defaults for the instruction-cache refill controller.
//   icache_refill_state_t : refill sequencer states
//   DEF_*                 : default geometry (16-byte line, 4-byte beat)
//   icache_line_adr_t     : tag/index/offset view of a byte address at the
//                           default geometry
// ----------------------------------------------------------------------------
package com_pkg;

    localparam int DEF_ADR_WIDTH  = 32;
    localparam int DEF_LINE_BYTES = 16;
    localparam int DEF_BUS_BYTES  = 4;
    localparam int DEF_INDEX_W    = 6;
    localparam int DEF_OFFSET_W   = $clog2(DEF_LINE_BYTES);
    localparam int DEF_TAG_W      = DEF_ADR_WIDTH - DEF_INDEX_W - DEF_OFFSET_W;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        BEAT,
        DRAIN,
        COMMIT
    } icache_refill_state_t;

    typedef struct packed {
        logic [DEF_TAG_W-1:0]    tag;
        logic [DEF_INDEX_W-1:0]  index;
        logic [DEF_OFFSET_W-1:0] offset;
    } icache_line_adr_t;

endpackage

// File: rtl/icache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// icache_refill_ctrl
// Miss/refill sequencer between the i-cache arrays and the memory bus.
// A miss invalidates the target line, issues one burst read, writes every
// returned beat into the data array and commits the tag when the line is
// complete. A flush (fetch redirect) drains the outstanding burst without
// committing.
//
// Optional feature macro: ICACHE_CRITICAL_WORD_FIRST_EN
//   defined   : request starts at the missing word, beats wrap, and the first
//               beat is forwarded on cwf_valid/cwf_data.
//   undefined : request at line base, start word 0, no cwf ports.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   miss_valid/adr      miss from the i-cache; miss_ready high only in IDLE
//   flush               abandon the current refill
//   mem_req_*           burst read request (held until accepted)
//   mem_rsp_*           returned beats (never stalled), with error flag
//   arr_*               data array write port
//   tag_we/value/valid  tag array write port
//   refill_done/err     completion pulse, err qualifies it
//   busy                state != IDLE
// ----------------------------------------------------------------------------
module icache_refill_ctrl
    import com_pkg::*;
#(
    parameter  int ADR_WIDTH  = DEF_ADR_WIDTH,
    parameter  int LINE_BYTES = DEF_LINE_BYTES,
    parameter  int BUS_BYTES  = DEF_BUS_BYTES,
    parameter  int INDEX_W    = DEF_INDEX_W,
    localparam int OFFSET_W   = $clog2(LINE_BYTES),
    localparam int BEATS      = LINE_BYTES / BUS_BYTES,
    localparam int BEATS_LOG  = $clog2(BEATS),
    localparam int WORD_W     = (BEATS_LOG < 1) ? 1 : BEATS_LOG,
    localparam int TAG_W      = ADR_WIDTH - INDEX_W - OFFSET_W,
    localparam int DATA_W     = BUS_BYTES * 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 miss_valid,
    input  logic [ADR_WIDTH-1:0] miss_adr,
    output logic                 miss_ready,
    input  logic                 flush,
    output logic                 mem_req_valid,
    output logic [ADR_WIDTH-1:0] mem_req_adr,
    input  logic                 mem_req_ready,
    input  logic                 mem_rsp_valid,
    input  logic [DATA_W-1:0]    mem_rsp_data,
    input  logic                 mem_rsp_err,
    output logic                 arr_we,
    output logic [INDEX_W-1:0]   arr_index,
    output logic [WORD_W-1:0]    arr_word,
    output logic [DATA_W-1:0]    arr_wdata,
    output logic                 tag_we,
    output logic [TAG_W-1:0]     tag_value,
    output logic                 tag_valid,
    output logic                 refill_done,
    output logic                 refill_err,
    output logic                 busy
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    ,
    output logic                 cwf_valid,
    output logic [DATA_W-1:0]    cwf_data
`endif
);

    localparam int BUS_OFF_W = $clog2(BUS_BYTES);
    localparam int CNT_W     = WORD_W + 1;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } line_adr_t;

    icache_refill_state_t state_q, state_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [WORD_W-1:0]    sword_q, sword_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 abort_q, abort_d;

    line_adr_t            miss_a;
    logic [WORD_W-1:0]    miss_word;
    logic [OFFSET_W-1:0]  req_off;
    logic [WORD_W-1:0]    slot;
    logic                 last_beat;

    assign miss_a    = line_adr_t'(miss_adr);
    assign miss_word = WORD_W'(miss_a.offset >> BUS_OFF_W);
    // Request offset is the start word scaled back to bytes (zero without CWF).
    assign req_off   = OFFSET_W'(sword_q) << BUS_OFF_W;
    // Power-of-two BEATS: the WORD_W-bit sum wraps modulo BEATS by itself.
    assign slot      = (BEATS == 1) ? '0 : WORD_W'(sword_q + cnt_q[WORD_W-1:0]);
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        index_d       = index_q;
        sword_d       = sword_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        abort_d       = abort_q;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_adr   = '0;
        arr_we        = 1'b0;
        arr_index     = '0;
        arr_word      = '0;
        arr_wdata     = '0;
        tag_we        = 1'b0;
        tag_value     = '0;
        tag_valid     = 1'b0;
        refill_done   = 1'b0;
        refill_err    = 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        cwf_valid     = 1'b0;
        cwf_data      = '0;
`endif
        case (state_q)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid && !flush) begin
                    // Invalidate the victim line in the same cycle the miss is taken.
                    tag_we    = 1'b1;
                    tag_value = miss_a.tag;
                    arr_index = miss_a.index;
                    tag_d     = miss_a.tag;
                    index_d   = miss_a.index;
                    sword_d   = CWF ? miss_word : '0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    abort_d   = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_adr   = {tag_q, index_q, req_off};
                arr_index     = index_q;
                if (flush) abort_d = 1'b1;
                // A flush coinciding with the accept still aborts the burst.
                if (mem_req_ready) state_d = (abort_q || flush) ? DRAIN : BEAT;
            end
            BEAT: begin
                arr_index = index_q;
                if (mem_rsp_valid) begin
                    arr_we    = 1'b1;
                    arr_word  = slot;
                    arr_wdata = mem_rsp_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (mem_rsp_err) err_d = 1'b1;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                    if (cnt_q == '0 && !flush) begin
                        cwf_valid = 1'b1;
                        cwf_data  = mem_rsp_data;
                    end
`endif
                end
                if (flush) begin
                    abort_d = 1'b1;
                    state_d = (mem_rsp_valid && last_beat) ? IDLE : DRAIN;
                end else if (mem_rsp_valid && last_beat) begin
                    state_d = COMMIT;
                end
            end
            DRAIN: begin
                arr_index = index_q;
                if (mem_rsp_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = IDLE;
                end
            end
            COMMIT: begin
                arr_index   = index_q;
                tag_value   = tag_q;
                tag_we      = !err_q;
                tag_valid   = !err_q;
                refill_done = 1'b1;
                refill_err  = err_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    // Line address capture: only meaningful once a miss has been taken.
    always_ff @(posedge clk) begin
        tag_q   <= tag_d;
        index_q <= index_d;
        sword_q <= sword_d;
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// tb_icache_refill_ctrl
// Directed bench for icache_refill_ctrl at the default 16/4 geometry.
// ----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_valid;
    logic [31:0] miss_adr;
    logic        miss_ready;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_adr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        arr_we;
    logic [5:0]  arr_index;
    logic [1:0]  arr_word;
    logic [31:0] arr_wdata;
    logic        tag_we;
    logic [21:0] tag_value;
    logic        tag_valid;
    logic        refill_done;
    logic        refill_err;
    logic        busy;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic        cwf_valid;
    logic [31:0] cwf_data;
`endif

    int ntests = 0;
    int nfail  = 0;

    icache_refill_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_valid   (miss_valid),
        .miss_adr     (miss_adr),
        .miss_ready   (miss_ready),
        .flush        (flush),
        .mem_req_valid(mem_req_valid),
        .mem_req_adr  (mem_req_adr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .mem_rsp_err  (mem_rsp_err),
        .arr_we       (arr_we),
        .arr_index    (arr_index),
        .arr_word     (arr_word),
        .arr_wdata    (arr_wdata),
        .tag_we       (tag_we),
        .tag_value    (tag_value),
        .tag_valid    (tag_valid),
        .refill_done  (refill_done),
        .refill_err   (refill_err),
        .busy         (busy)
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        ,
        .cwf_valid    (cwf_valid),
        .cwf_data     (cwf_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_req(input logic [31:0] a);
        return CWF ? (a & 32'hFFFF_FFFC) : (a & 32'hFFFF_FFF0);
    endfunction

    function automatic logic [1:0] exp_word(input int sw, input int i);
        return CWF ? 2'((sw + i) % 4) : 2'(i);
    endfunction

    // Four back-to-back written beats; err_beat < 0 means no error.
    task automatic run_beats(input int sw, input logic [31:0] base, input int err_beat,
                             input logic [5:0] idx);
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = base + 32'(i);
            mem_rsp_err   = (i == err_beat);
            settle();
            chk($sformatf("beat%0d_we", i), 64'(arr_we), 64'd1);
            chk($sformatf("beat%0d_word", i), 64'(arr_word), 64'(exp_word(sw, i)));
            chk($sformatf("beat%0d_wdata", i), 64'(arr_wdata), 64'(base + 32'(i)));
            chk($sformatf("beat%0d_index", i), 64'(arr_index), 64'(idx));
            chk($sformatf("beat%0d_nodone", i), 64'(refill_done), 64'd0);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            chk($sformatf("beat%0d_cwf", i), 64'(cwf_valid), (i == 0) ? 64'd1 : 64'd0);
            if (i == 0) chk("cwf_data", 64'(cwf_data), 64'(base));
`endif
            adv();
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_data  = '0;
    endtask

    initial begin
        rst_n = 1'b0; miss_valid = 1'b0; miss_adr = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        settle();
        chk("rst_miss_ready", 64'(miss_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_tag_we", 64'(tag_we), 64'd0);
        chk("rst_arr_we", 64'(arr_we), 64'd0);
        chk("rst_done", 64'(refill_done), 64'd0);
        adv();

        // Clean refill of 0x1238: tag 0x4, index 0x23, miss word 2
        miss_valid = 1'b1; miss_adr = 32'h0000_1238;
        settle();
        chk("t1_inv_we", 64'(tag_we), 64'd1);
        chk("t1_inv_valid", 64'(tag_valid), 64'd0);
        chk("t1_inv_tag", 64'(tag_value), 64'h4);
        chk("t1_inv_index", 64'(arr_index), 64'h23);
        adv();
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        settle();
        chk("t1_req_valid", 64'(mem_req_valid), 64'd1);
        chk("t1_req_adr", 64'(mem_req_adr), 64'(exp_req(32'h0000_1238)));
        chk("t1_miss_ready", 64'(miss_ready), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        adv();
        mem_req_ready = 1'b0;
        run_beats(2, 32'hA000_0000, -1, 6'h23);
        settle();
        chk("t1_commit_we", 64'(tag_we), 64'd1);
        chk("t1_commit_valid", 64'(tag_valid), 64'd1);
        chk("t1_commit_tag", 64'(tag_value), 64'h4);
        chk("t1_done", 64'(refill_done), 64'd1);
        chk("t1_err", 64'(refill_err), 64'd0);
        adv();
        settle();
        chk("t1_back_idle", 64'(miss_ready), 64'd1);
        chk("t1_done_pulse", 64'(refill_done), 64'd0);
        adv();

        // Slow request accept + error on beat 2 (0x4570: tag 0x11, index 0x17)
        miss_valid = 1'b1; miss_adr = 32'h0000_4570;
        adv();
        miss_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t2_hold_valid", 64'(mem_req_valid), 64'd1);
            chk("t2_hold_adr", 64'(mem_req_adr), 64'h4570);
            chk("t2_no_write", 64'(arr_we), 64'd0);
            adv();
        end
        mem_req_ready = 1'b1;
        settle();
        chk("t2_req_valid", 64'(mem_req_valid), 64'd1);
        adv();
        mem_req_ready = 1'b0;
        run_beats(0, 32'hB000_0000, 2, 6'h17);
        settle();
        chk("t2_commit_we", 64'(tag_we), 64'd0);
        chk("t2_done", 64'(refill_done), 64'd1);
        chk("t2_err", 64'(refill_err), 64'd1);
        adv();

        // Miss together with flush is ignored
        miss_valid = 1'b1; flush = 1'b1; miss_adr = 32'h0000_1238;
        settle();
        chk("t3_ign_tag_we", 64'(tag_we), 64'd0);
        adv();
        miss_valid = 1'b0; flush = 1'b0;
        settle();
        chk("t3_ign_busy", 64'(busy), 64'd0);
        adv();

        // Reset in the middle of a refill
        miss_valid = 1'b1;
        adv();
        miss_valid = 1'b0;
        settle();
        chk("t4_pre_busy", 64'(busy), 64'd1);
        adv();
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
        settle();
        chk("t4_rst_busy", 64'(busy), 64'd0);
        chk("t4_rst_req", 64'(mem_req_valid), 64'd0);
        chk("t4_rst_ready", 64'(miss_ready), 64'd1);
        adv();

        // Flush with beat 1: beats 0-1 written, 2-3 drained
        miss_valid = 1'b1; miss_adr = 32'h0000_1238;
        adv();
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        adv();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h10;
        settle();
        chk("t5_b0_we", 64'(arr_we), 64'd1);
        adv();
        mem_rsp_data = 32'h11; flush = 1'b1;
        settle();
        chk("t5_b1_we", 64'(arr_we), 64'd1);
        chk("t5_b1_word", 64'(arr_word), 64'(exp_word(2, 1)));
        chk("t5_b1_data", 64'(arr_wdata), 64'h11);
        adv();
        flush = 1'b0;
        for (int i = 2; i < 4; i++) begin
            mem_rsp_data = 32'(i);
            settle();
            chk("t5_drain_we", 64'(arr_we), 64'd0);
            chk("t5_drain_done", 64'(refill_done), 64'd0);
            chk("t5_drain_ready", 64'(miss_ready), 64'd0);
            adv();
        end
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        settle();
        chk("t5_idle_ready", 64'(miss_ready), 64'd1);
        chk("t5_idle_done", 64'(refill_done), 64'd0);
        chk("t5_idle_tag_we", 64'(tag_we), 64'd0);
        adv();

        // New miss after the drain proceeds normally (0x4: tag 0, index 0, word 1)
        miss_valid = 1'b1; miss_adr = 32'h0000_0004;
        settle();
        chk("t6_inv_we", 64'(tag_we), 64'd1);
        chk("t6_inv_valid", 64'(tag_valid), 64'd0);
        adv();
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        settle();
        chk("t6_req_adr", 64'(mem_req_adr), 64'(exp_req(32'h0000_0004)));
        adv();
        mem_req_ready = 1'b0;
        run_beats(1, 32'hC000_0000, -1, 6'h00);
        settle();
        chk("t6_commit_we", 64'(tag_we), 64'd1);
        chk("t6_commit_tag", 64'(tag_value), 64'h0);
        chk("t6_done", 64'(refill_done), 64'd1);
        chk("t6_err", 64'(refill_err), 64'd0);
        adv();

        // Flush during REQ: request held, then all beats drained
        miss_valid = 1'b1; miss_adr = 32'h0000_4570;
        adv();
        miss_valid = 1'b0; flush = 1'b1;
        settle();
        chk("t7_req_flush", 64'(mem_req_valid), 64'd1);
        adv();
        flush = 1'b0;
        settle();
        chk("t7_req_held", 64'(mem_req_valid), 64'd1);
        chk("t7_req_adr", 64'(mem_req_adr), 64'h4570);
        adv();
        mem_req_ready = 1'b1;
        adv();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'hD0 + 32'(i);
            settle();
            chk("t7_drain_we", 64'(arr_we), 64'd0);
            chk("t7_drain_busy", 64'(busy), 64'd1);
            chk("t7_drain_done", 64'(refill_done), 64'd0);
            adv();
        end
        mem_rsp_valid = 1'b0;
        settle();
        chk("t7_idle_busy", 64'(busy), 64'd0);
        chk("t7_idle_done", 64'(refill_done), 64'd0);
        chk("t7_idle_tag_we", 64'(tag_we), 64'd0);
        adv();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
